// File: rtl/word_block_packer_if.sv
// Word-in / block-out handshake bundle for word_block_packer.
// The slave modport is the packer's view; the master modport is the view of the surrounding logic.
interface word_block_packer_if #(
  parameter int WSIZE = 32,
  parameter int WORDS = 4
);
  localparam int BSIZE = WSIZE * WORDS;
  localparam int CW    = $clog2(WORDS + 1);

  logic [WSIZE-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic             flush;
  logic [BSIZE-1:0] out_block;
  logic [CW-1:0]    out_count;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    pending;

  modport master (
    output in_data, in_valid, in_last, flush, out_ready,
    input  in_ready, out_block, out_count, out_valid, pending
  );

  modport slave (
    input  in_data, in_valid, in_last, flush, out_ready,
    output in_ready, out_block, out_count, out_valid, pending
  );
endinterface

// File: rtl/word_block_packer.sv
// Gathers WORDS words into one block and queues up to OUT_DEPTH finished blocks.
// A block closes when its last slot fills, on in_last, or on a flush of a non-empty partial block.
module word_block_packer #(
  parameter int WSIZE     = 32,
  parameter int WORDS     = 4,
  parameter int MSW_FIRST = 1,
  parameter int OUT_DEPTH = 2
) (
  input logic               clock,
  input logic               reset,
  word_block_packer_if.slave bus
);
  localparam int BSIZE = WSIZE * WORDS;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OW    = $clog2(OUT_DEPTH + 1);

  logic [CW-1:0]    idx;
  logic [BSIZE-1:0] acc;
  logic [BSIZE-1:0] acc_with_word;
  logic [BSIZE-1:0] push_block;
  logic [CW-1:0]    push_count;

  logic [BSIZE-1:0] q_block [OUT_DEPTH];
  logic [CW-1:0]    q_count [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [BSIZE-1:0] last_block;
  logic [CW-1:0]    last_count;

  logic in_ready_int;
  logic q_valid;
  logic accept;
  logic take_flush;
  logic close_word;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // in_ready depends only on registered occupancy and reset, never on out_ready.
  assign in_ready_int = !reset && (occ < OW'(OUT_DEPTH));
  assign q_valid      = (occ != '0);
  assign accept       = bus.in_valid && in_ready_int;
  assign take_flush   = bus.flush && !bus.in_valid && in_ready_int && (idx != '0);
  assign close_word   = accept && (bus.in_last || (idx == CW'(WORDS - 1)));
  assign push         = close_word || take_flush;
  assign pop          = q_valid && bus.out_ready;

  always_comb begin
    acc_with_word = acc;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == CW'(k)) begin
        acc_with_word[((MSW_FIRST != 0) ? (WORDS - 1 - k) : k) * WSIZE +: WSIZE] = bus.in_data;
      end
    end
  end

  assign push_block = close_word ? acc_with_word : acc;
  assign push_count = close_word ? idx + CW'(1) : idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      acc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      last_block <= '0;
      last_count <= '0;
    end else begin
      if (push) begin
        idx <= '0;
        acc <= '0;
      end else if (accept) begin
        idx <= idx + CW'(1);
        acc <= acc_with_word;
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        last_block <= q_block[rd_ptr];
        last_count <= q_count[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Queue storage needs no reset: it is only visible through q_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      q_block[wr_ptr] <= push_block;
      q_count[wr_ptr] <= push_count;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = q_valid;
  assign bus.out_block = q_valid ? q_block[rd_ptr] : last_block;
  assign bus.out_count = q_valid ? q_count[rd_ptr] : last_count;
  assign bus.pending   = idx;
endmodule

// File: tb/tb_word_block_packer.sv
// Drives an MSW-first and an LSW-first packer with identical stimulus and
// checks both against a queue-based model of words and finished blocks.
module tb_word_block_packer;
  localparam int WSIZE     = 32;
  localparam int WORDS     = 4;
  localparam int OUT_DEPTH = 2;
  localparam int BSIZE     = WSIZE * WORDS;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [WSIZE-1:0] in_data;
  logic in_valid, in_last, flush, out_ready;

  int checks = 0;
  int errors = 0;

  word_block_packer_if #(.WSIZE(WSIZE), .WORDS(WORDS)) if_m ();
  word_block_packer_if #(.WSIZE(WSIZE), .WORDS(WORDS)) if_l ();

  assign if_m.in_data   = in_data;
  assign if_m.in_valid  = in_valid;
  assign if_m.in_last   = in_last;
  assign if_m.flush     = flush;
  assign if_m.out_ready = out_ready;
  assign if_l.in_data   = in_data;
  assign if_l.in_valid  = in_valid;
  assign if_l.in_last   = in_last;
  assign if_l.flush     = flush;
  assign if_l.out_ready = out_ready;

  word_block_packer #(.WSIZE(WSIZE), .WORDS(WORDS), .MSW_FIRST(1), .OUT_DEPTH(OUT_DEPTH))
    dut_m (.clock(clock), .reset(reset), .bus(if_m));
  word_block_packer #(.WSIZE(WSIZE), .WORDS(WORDS), .MSW_FIRST(0), .OUT_DEPTH(OUT_DEPTH))
    dut_l (.clock(clock), .reset(reset), .bus(if_l));

  // Model: words of the open block, plus the queue of finished blocks in both orders.
  logic [WSIZE-1:0] cur [$];
  logic [BSIZE-1:0] q_msw [$];
  logic [BSIZE-1:0] q_lsw [$];
  int               q_cnt [$];
  logic             acc_flag;

  function automatic logic [BSIZE-1:0] build(input bit msw);
    logic [BSIZE-1:0] b;
    int pos;
    b = '0;
    for (int i = 0; i < cur.size(); i++) begin
      pos = msw ? (WORDS - 1 - i) : i;
      b = b | (BSIZE'(cur[i]) << (pos * WSIZE));
    end
    return b;
  endfunction

  task automatic close_block();
    q_msw.push_back(build(1'b1));
    q_lsw.push_back(build(1'b0));
    q_cnt.push_back(cur.size());
    cur.delete();
  endtask

  task automatic check(input string tag, input logic [BSIZE-1:0] obs, input logic [BSIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; checks at the falling edge, model advances at the next rising edge.
  task automatic step(input logic v, input logic [WSIZE-1:0] d, input logic l, input logic f,
                      input logic ordy, output logic accepted);
    logic exp_ready, exp_valid, fl, pop;
    in_valid = v; in_data = d; in_last = l; flush = f; out_ready = ordy;
    @(negedge clock);
    exp_ready = (q_cnt.size() < OUT_DEPTH);
    exp_valid = (q_cnt.size() > 0);
    check("in_ready_m", BSIZE'(if_m.in_ready), BSIZE'(exp_ready));
    check("in_ready_l", BSIZE'(if_l.in_ready), BSIZE'(exp_ready));
    check("out_valid_m", BSIZE'(if_m.out_valid), BSIZE'(exp_valid));
    check("out_valid_l", BSIZE'(if_l.out_valid), BSIZE'(exp_valid));
    check("pending_m", BSIZE'(if_m.pending), BSIZE'(cur.size()));
    check("pending_l", BSIZE'(if_l.pending), BSIZE'(cur.size()));
    if (exp_valid) begin
      check("block_m", if_m.out_block, q_msw[0]);
      check("block_l", if_l.out_block, q_lsw[0]);
      check("count_m", BSIZE'(if_m.out_count), BSIZE'(q_cnt[0]));
      check("count_l", BSIZE'(if_l.out_count), BSIZE'(q_cnt[0]));
    end
    accepted = v && exp_ready;
    fl  = f && !v && exp_ready && (cur.size() > 0);
    pop = exp_valid && ordy;
    @(posedge clock);
    #1;
    if (pop) begin
      void'(q_msw.pop_front());
      void'(q_lsw.pop_front());
      void'(q_cnt.pop_front());
    end
    if (accepted) begin
      cur.push_back(d);
      if (cur.size() == WORDS || l) close_block();
    end else if (fl) begin
      close_block();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, BSIZE'({if_m.in_ready, if_l.in_ready}), '0);
    check({tag, "_out_valid"}, BSIZE'({if_m.out_valid, if_l.out_valid}), '0);
    check({tag, "_pending"}, BSIZE'({if_m.pending, if_l.pending}), '0);
  endtask

  initial begin
    int j, cyc, d;
    logic ordy;
    in_valid = 0; in_last = 0; flush = 0; out_ready = 0; in_data = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("rst");
    check("rst_block_m", if_m.out_block, '0);
    check("rst_count_m", BSIZE'(if_m.out_count), '0);
    @(posedge clock); #1;
    reset = 0;

    // Full block, both orders
    step(1, 32'h11111111, 0, 0, 1, acc_flag);
    step(1, 32'h22222222, 0, 0, 1, acc_flag);
    step(1, 32'h33333333, 0, 0, 1, acc_flag);
    step(1, 32'h44444444, 0, 0, 1, acc_flag);
    check("full_valid", BSIZE'(if_m.out_valid), BSIZE'(1));
    check("full_msw", if_m.out_block, 128'h11111111_22222222_33333333_44444444);
    check("full_lsw", if_l.out_block, 128'h44444444_33333333_22222222_11111111);
    check("full_count", BSIZE'(if_m.out_count), BSIZE'(4));
    check("full_pending", BSIZE'(if_m.pending), '0);
    step(0, '0, 0, 0, 1, acc_flag);

    // Early close with in_last, then the next word restarts at slot 0
    step(1, 32'hA, 0, 0, 1, acc_flag);
    step(1, 32'hB, 1, 0, 1, acc_flag);
    check("early_msw", if_m.out_block, 128'h0000000A_0000000B_00000000_00000000);
    check("early_count", BSIZE'(if_m.out_count), BSIZE'(2));
    step(0, '0, 0, 0, 1, acc_flag);
    step(1, 32'hC, 0, 0, 1, acc_flag);
    step(0, '0, 0, 1, 1, acc_flag);
    check("slot0_msw", if_m.out_block, 128'h0000000C_00000000_00000000_00000000);
    check("slot0_count", BSIZE'(if_m.out_count), BSIZE'(1));
    step(0, '0, 0, 0, 1, acc_flag);

    // Flush of a 3-word block, then a flush with nothing pending
    step(1, 32'h1, 0, 0, 1, acc_flag);
    step(1, 32'h2, 0, 0, 1, acc_flag);
    step(1, 32'h3, 0, 0, 1, acc_flag);
    step(0, '0, 0, 1, 1, acc_flag);
    check("flush_count", BSIZE'(if_m.out_count), BSIZE'(3));
    step(0, '0, 0, 0, 1, acc_flag);
    step(0, '0, 0, 1, 1, acc_flag);
    step(0, '0, 0, 0, 1, acc_flag);
    check("flush_empty", BSIZE'({if_m.out_valid, if_l.out_valid}), '0);

    // Back-pressure: 12 words against a stalled consumer, released later
    j = 0; cyc = 0;
    while (j < 12 && cyc < 100) begin
      ordy = (cyc >= 14);
      step(1, 32'h100 + 32'(j), 0, 0, ordy, acc_flag);
      if (acc_flag) j++;
      if (!ordy && j == 8) check("stall_ready", BSIZE'(if_m.in_ready), '0);
      cyc++;
    end
    check("bp_accepted", BSIZE'(j), BSIZE'(12));
    d = 0;
    while (q_cnt.size() > 0 && d < 20) begin
      step(0, '0, 0, 0, 1, acc_flag);
      d++;
    end
    check("bp_drained", BSIZE'(if_m.out_valid), '0);

    // Random traffic
    repeat (400) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, acc_flag);
    end
    d = 0;
    while ((cur.size() > 0 || q_cnt.size() > 0) && d < 50) begin
      step(0, '0, 0, 1, 1, acc_flag);
      d++;
    end
    check("rand_drain_valid", BSIZE'({if_m.out_valid, if_l.out_valid}), '0);
    check("rand_drain_pending", BSIZE'({if_m.pending, if_l.pending}), '0);

    // Reset with one block queued and two words pending
    for (int i = 0; i < 6; i++) step(1, 32'hE0 + 32'(i), 0, 0, 0, acc_flag);
    check("pre_rst_pending", BSIZE'(if_m.pending), BSIZE'(2));
    #1 reset = 1;
    #1 check_reset_outputs("mid_rst");
    cur.delete(); q_msw.delete(); q_lsw.delete(); q_cnt.delete();
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 4; i++) step(1, 32'hD0 + 32'(i), 0, 0, 1, acc_flag);
    check("post_rst_msw", if_m.out_block, 128'h000000D0_000000D1_000000D2_000000D3);
    check("post_rst_count", BSIZE'(if_m.out_count), BSIZE'(4));
    step(0, '0, 0, 0, 1, acc_flag);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_block_packer.md
Name: word_block_packer

Overview:
- Parametrised word-to-block packer. Gathers WORDS input words of WSIZE bits into one block of WSIZE*WORDS bits using valid/ready handshakes on both sides.
- Supports early block termination (in_last or flush) with a valid-word count, and selectable word order.
- Holds up to OUT_DEPTH completed blocks, so the word source keeps streaming while the block consumer stalls.
- Sits between word-oriented producers (bus and FIFO side) and block-oriented engines.

Parameters:
- WSIZE, 32, input word width in bits (>=1).
- WORDS, 4, words per block (>=2; need not be a power of 2).
- MSW_FIRST, 1, 1: first accepted word lands in the most significant slot; 0: first word lands in the least significant slot.
- OUT_DEPTH, 2, number of completed-block queue entries (>=1).
- Derived: BSIZE = WSIZE*WORDS.
- Derived: CW = $clog2(WORDS+1).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  WSIZE  word to pack
- in_valid  input  1  in_data is valid
- in_ready  output  1  packer accepts a word or flush this cycle
- in_last  input  1  qualifies in_valid: this word closes the current block
- flush  input  1  close the current partial block without supplying a word
- out_block  output  BSIZE  head-of-queue block
- out_count  output  CW  number of valid words in out_block (1..WORDS)
- out_valid  output  1  queue non-empty
- out_ready  input  1  consumer takes out_block this cycle
- pending  output  CW  words held in the partial (unqueued) block

Behaviour:
- Clock and reset: already decided — reset reset, asynchronous, active-high; clock clock.
- Reset values:
  - slot index idx = 0, accumulator = 0, queue empty.
  - out_valid = 0, out_block = 0, out_count = 0, pending = 0.
  - in_ready = 0 while reset is high.
- Reset mid-block discards the partial block and all queued blocks.
- in_ready = !reset && (queue occupancy < OUT_DEPTH).
  - in_ready must have no combinational path from out_ready or in_valid.
- Word accept = in_valid && in_ready.
  - The accepted word is written to slot idx.
  - MSW_FIRST=1: slot k occupies bits [(WORDS-k)*WSIZE-1 -: WSIZE].
  - MSW_FIRST=0: slot k occupies bits [k*WSIZE +: WSIZE].
- Block close on a word accept when idx == WORDS-1 or in_last == 1:
  - Push {accumulator with the new word, count = idx+1} into the queue.
  - Unused slots are zero. Accumulator clears and idx returns to 0 in the same edge.
- No close: idx <= idx+1.
- Flush is honoured only when in_ready=1 and in_valid=0.
  - If idx > 0: push the partial block with count = idx, then idx <= 0.
  - If idx == 0: no-op; empty blocks are never emitted.
  - The source holds flush until in_ready=1.
  - flush with in_valid=1 is ignored; in_last is the only close mechanism in that case.
- Queue:
  - FIFO order; out_block, out_count and out_valid are driven from the head entry and held stable while out_valid && !out_ready.
  - Pop = out_valid && out_ready.
  - Simultaneous push and pop when not full: occupancy unchanged, head advances, new entry appended.
  - Push while full is impossible because in_ready=0.
  - Pointers wrap modulo OUT_DEPTH, with occupancy tracked in a separate counter.
- Latency: the block appears on out_valid on the clock edge that accepts its closing word or flush, i.e. visible the following cycle. Minimum word-to-block latency is 1 cycle.
- Throughput:
  - One word per cycle sustained while out_ready=1.
  - A block of WORDS words takes exactly WORDS accept cycles.
- pending = idx, updated registered.
- When out_valid=0, out_block and out_count show the last popped values. Only the fields qualified by out_valid are checked.

Test Plan:
- Full block, MSW_FIRST=1, WORDS=4, out_ready=1:
  - Stimulus: feed 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - Response: one cycle after the 4th accept, out_valid=1, out_block=0x11111111_22222222_33333333_44444444, out_count=4, pending=0.
- LSW-first order, MSW_FIRST=0:
  - Stimulus: same four words.
  - Response: out_block=0x44444444_33333333_22222222_11111111.
- Early close:
  - Stimulus: words 0xA, then 0xB with in_last=1.
  - Response: out_count=2, out_block=0x0000000A_0000000B_00000000_00000000. The next word goes to slot 0.
- Flush:
  - Stimulus: 3 words, then a flush pulse; then a second flush with idx=0.
  - Response: first flush gives out_count=3; second flush produces no block and out_valid stays 0 after the pop.
- Back-pressure, OUT_DEPTH=2, out_ready=0:
  - Stimulus: stream 12 words.
  - Response: in_ready drops to 0 after the 8th accept (2 blocks queued). Words 9-12 stall.
  - Then raise out_ready: blocks pop in order and the 3rd block completes with no word lost or duplicated.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously after 2 words, with 1 block queued.
  - Response: out_valid=0, pending=0, in_ready=0 immediately. After release, a fresh 4-word block packs from slot 0.
